io_request_responder: RTL
=========================

// Module: io_request_responder
// PURPOSE
// Peripheral-side responder to the control unit's I/O request lines (is_input/is_output).
// Holds each request until the user confirms on a debounced push button, then returns a
// one-cycle confirmation pulse to the control unit.
// Input requests return the switch value sampled at the press. Output requests latch CPU
// data onto the display register. Sits between the board I/O and the control unit.
// PARAMETERS
// DATA_WIDTH       32      width of data_from_cpu, data_to_cpu, display_value
// SWITCH_WIDTH     16      width of switches, zero-extended to DATA_WIDTH (<= DATA_WIDTH)
// DEBOUNCE_CYCLES  500000  stable cycles needed to accept a button level change (>= 2)
// PORTS
// clock           in   1             single system clock, rising edge
// reset           in   1             asynchronous, active-low; 0 = reset
// is_input        in   1             CPU input request, level, held until confirmation
// is_output       in   1             CPU output request, level, held until confirmation
// data_from_cpu   in   DATA_WIDTH    value to display, valid while is_output=1
// switches        in   SWITCH_WIDTH  raw board switches, quasi-static
// confirm_button  in   1             raw push button, asynchronous, active-high
// confirmation    out  1             one-cycle pulse, request serviced
// data_to_cpu     out  DATA_WIDTH    last input value, held until the next input completes
// display_value   out  DATA_WIDTH    last output value, held
// waiting_user    out  1             1 while a request awaits the button (LED)
// request_error   out  1             sticky; set if is_input and is_output are high together
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; every output 0; debouncer cleared to released.
// - confirm_button passes a 2-flop synchronizer, then the debouncer. Debounced level changes
//   only after DEBOUNCE_CYCLES consecutive equal synchronized samples. Latency is
//   2+DEBOUNCE_CYCLES cycles. The debouncer gives 1-cycle press_evt and release_evt.
// - FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, ACK, DONE.
//   IDLE: if is_input|is_output -> WAIT_PRESS; latch req_is_input=is_input.
//     If both are high, input wins and request_error is set.
//     If is_output, display_value <= data_from_cpu in the same cycle.
//     A button already held in IDLE is ignored; only a press_evt seen in WAIT_PRESS counts.
//   WAIT_PRESS: waiting_user=1. On press_evt -> WAIT_RELEASE; if input, capture switches.
//   WAIT_RELEASE: waiting_user=1. On release_evt -> ACK.
//   ACK: confirmation=1 for exactly this cycle. If input, data_to_cpu <= captured value.
//     Then -> DONE.
//   DONE: wait until is_input=0 and is_output=0, then -> IDLE. This stops a held request
//     from being serviced twice.
// - Abort: if both request lines drop in WAIT_PRESS or WAIT_RELEASE -> IDLE.
//   No confirmation; data_to_cpu unchanged; display_value keeps the value already latched.
// - A change of request type mid-wait is ignored; the latched type is used.
// - Press-to-confirmation latency: press_evt cycle + release_evt + 1 cycle (ACK).
//   Minimum request-to-confirmation is 3 + 2*(2+DEBOUNCE_CYCLES) cycles.
// - Debounce counter width is clog2(DEBOUNCE_CYCLES+1). It saturates and resets on any
//   sample change; it never wraps.
// - Reset mid-operation aborts silently and no confirmation is emitted.
//   request_error is cleared only by reset.
// STRUCTURE
// - Shared package/header io_defs: FSM state localparams (3-bit encoding), default
//   DEBOUNCE_CYCLES, SWITCH_WIDTH.
// - One sub-module: button_debouncer (synchronizer + counter + edge events), parameterised
//   by DEBOUNCE_CYCLES.
// - Top: FSM, capture registers, output registers. All outputs are registered except
//   waiting_user, which is decoded from state.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
// 1. Release reset, assert is_input, switches=16'hA5C3, press 10 cycles, release ->
//    one confirmation pulse; data_to_cpu=32'h0000A5C3; waiting_user 1 until ACK.
// 2. Assert is_output, data_from_cpu=32'hDEADBEEF -> display_value=32'hDEADBEEF one cycle
//    after the request. Press/release -> confirmation pulse. Keep is_output high 20 more
//    cycles -> no second pulse.
// 3. Button bounce: toggle every 2 cycles for 12 cycles, then hold for 10 cycles ->
//    exactly one press_evt, and no ACK before release.
// 4. is_input and is_output both high, switches=16'h0001 -> treated as input;
//    request_error=1 stays set after completion; data_to_cpu=1.
// 5. Abort: is_input high, drop it in WAIT_PRESS, then press -> no confirmation;
//    data_to_cpu keeps its previous value; state IDLE.
// 6. Pull reset low in WAIT_RELEASE -> all outputs 0 at once (async).
//    After release, a new input request completes normally.

Source files
------------

// File: rtl/io_request_responder_pkg.sv
// Shared definitions for the I/O request responder slice.
// Purpose: FSM state encoding, default parameter values and a small state decode helper.
// Ports: none (package).
package io_request_responder_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_SWITCH_WIDTH    = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        WAIT_RELEASE = 3'd2,
        ACK          = 3'd3,
        DONE         = 3'd4
    } state_t;

    // True while a request is parked waiting for the user to press/release the button.
    function automatic logic is_waiting(input state_t s);
        return (s == WAIT_PRESS) || (s == WAIT_RELEASE);
    endfunction

endpackage

// File: rtl/io_request_responder_if.sv
// Control-unit side handshake bundle of the I/O request responder.
// Purpose: groups the request lines, CPU data and the responder's replies.
// Signals: is_input/is_output (request levels), data_from_cpu (value to display),
//          confirmation (one-cycle service pulse), data_to_cpu (last input value),
//          request_error (sticky, both request lines seen high together).
// Modports: master = control unit, slave = responder.
interface io_request_responder_if
    import io_request_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  is_input;
    logic                  is_output;
    logic [DATA_WIDTH-1:0] data_from_cpu;
    logic                  confirmation;
    logic [DATA_WIDTH-1:0] data_to_cpu;
    logic                  request_error;

    modport master (
        output is_input,
        output is_output,
        output data_from_cpu,
        input  confirmation,
        input  data_to_cpu,
        input  request_error
    );

    modport slave (
        input  is_input,
        input  is_output,
        input  data_from_cpu,
        output confirmation,
        output data_to_cpu,
        output request_error
    );

endinterface

// File: rtl/io_request_responder_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and edge events.
// Ports: clock, reset (async, active-low), button_raw (asynchronous button level),
//        press_evt / release_evt (one-cycle pulses when the debounced level changes).
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples
// that disagree with it, so total latency from the raw pin is 2 + DEBOUNCE_CYCLES cycles.
module io_request_responder_debouncer
    import io_request_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic press_evt,
    output logic release_evt
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_0;
    logic             sync_1;
    logic             debounced_level;
    logic [CNT_W-1:0] stable_count;

    // A sample equal to the current level means the input changed back (or never left),
    // so the run of disagreeing samples restarts. The counter saturates rather than wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_0          <= 1'b0;
            sync_1          <= 1'b0;
            debounced_level <= 1'b0;
            stable_count    <= '0;
            press_evt       <= 1'b0;
            release_evt     <= 1'b0;
        end else begin
            sync_0      <= button_raw;
            sync_1      <= sync_0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            if (sync_1 == debounced_level) begin
                stable_count <= '0;
            end else if (stable_count == CNT_LAST) begin
                debounced_level <= sync_1;
                stable_count    <= '0;
                press_evt       <= sync_1;
                release_evt     <= !sync_1;
            end else if (stable_count != CNT_MAX) begin
                stable_count <= stable_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_request_responder.sv
// Peripheral-side responder to the control unit's I/O requests.
// Ports: clock, reset (async, active-low), bus (slave modport: request lines, CPU data,
//        confirmation, data_to_cpu, request_error), switches (raw board switches),
//        confirm_button (raw push button), display_value (last output value),
//        waiting_user (LED, request awaiting the button).
// A request is held until a full debounced press+release, then acknowledged with a
// one-cycle confirmation. Input requests return the switches sampled at the press;
// output requests latch CPU data onto the display as soon as they are accepted.
module io_request_responder
    import io_request_responder_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int SWITCH_WIDTH    = DEFAULT_SWITCH_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    io_request_responder_if.slave   bus,
    input  logic [SWITCH_WIDTH-1:0] switches,
    input  logic                    confirm_button,
    output logic [DATA_WIDTH-1:0]   display_value,
    output logic                    waiting_user
);

    state_t                state;
    state_t                next_state;
    logic                  press_evt;
    logic                  release_evt;
    logic                  request_pending;
    logic                  req_is_input;
    logic [DATA_WIDTH-1:0] captured_value;

    io_request_responder_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock       (clock),
        .reset       (reset),
        .button_raw  (confirm_button),
        .press_evt   (press_evt),
        .release_evt (release_evt)
    );

    assign request_pending = bus.is_input || bus.is_output;
    assign waiting_user    = is_waiting(state);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping both request lines while waiting aborts; DONE blocks a still-held
    // request from being serviced a second time.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request_pending) next_state = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!request_pending) next_state = IDLE;
                else if (press_evt)   next_state = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!request_pending) next_state = IDLE;
                else if (release_evt) next_state = ACK;
            end
            ACK: begin
                next_state = DONE;
            end
            DONE: begin
                if (!request_pending) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request type is latched once on acceptance; later changes on the lines are ignored.
    // Confirmation and returned data are registered on entry to ACK so they appear together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_is_input      <= 1'b0;
            captured_value    <= '0;
            display_value     <= '0;
            bus.confirmation  <= 1'b0;
            bus.data_to_cpu   <= '0;
            bus.request_error <= 1'b0;
        end else begin
            bus.confirmation <= (next_state == ACK);
            if (state == IDLE && request_pending) begin
                req_is_input <= bus.is_input;
                if (bus.is_input && bus.is_output) bus.request_error <= 1'b1;
                if (bus.is_output) display_value <= bus.data_from_cpu;
            end
            if (state == WAIT_PRESS && next_state == WAIT_RELEASE && req_is_input) begin
                captured_value <= DATA_WIDTH'(switches);
            end
            if (next_state == ACK && req_is_input) begin
                bus.data_to_cpu <= captured_value;
            end
        end
    end

endmodule
